m_fetch_queue: RTL and testbench

//  Prefetching IF stage: drives instruction-memory address, captures fetched words with PC and branch

---
 rtl/m_fetch_queue.sv | 82 ++++++++
 tb/tb_m_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/m_fetch_queue.sv
// m_fetch_queue: prefetching IF stage feeding a small instruction FIFO in front of ID
module m_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          w_clk,
   input  logic          w_rst_n,
   output logic [AW-1:0] w_imem_addr,
   input  logic [DW-1:0] w_imem_data,
   input  logic          w_pre,
   input  logic          w_pr,
   input  logic [AW-1:0] w_pdst,
   input  logic          w_redirect,
   input  logic [AW-1:0] w_redirect_pc,
   input  logic          w_halt,
   input  logic          w_id_ready,
   output logic          w_ir_valid,
   output logic [DW-1:0] w_ir,
   output logic [AW-1:0] w_ir_pc,
   output logic [AW-1:0] w_ir_pc4,
   output logic          w_ir_pr
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [AW-1:0]    r_fpc, r_fl_pc;
   logic             r_fl_v, r_fl_pr;
   logic [PW-1:0]    r_head, r_tail;
   logic [CW-1:0]    r_count, occ;
   logic [DW-1:0]    q_ir [DEPTH];
   logic [AW-1:0]    q_pc [DEPTH];
   logic [DEPTH-1:0] q_pr;
   logic             taken, fire, push, pop;
   assign occ = r_count + CW'(r_fl_v);
   assign taken = w_pre && w_pr;
   assign fire = !w_halt && !w_redirect && occ < CW'(DEPTH);
   assign push = r_fl_v && !w_redirect;
   assign pop = w_ir_valid && w_id_ready && !w_redirect;
   assign w_imem_addr = r_fpc;
   assign w_ir_valid = r_count != '0;
   assign w_ir = w_ir_valid ? q_ir[r_head] : DW'(32'h20);
   assign w_ir_pc = w_ir_valid ? q_pc[r_head] : '0;
   assign w_ir_pc4 = w_ir_valid ? q_pc[r_head] + AW'(1) : '0;
   assign w_ir_pr = w_ir_valid && q_pr[r_head];
   // fetch PC and the single in-flight slot (a queue slot is reserved when a fetch issues)
   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_fpc <= '0;
         r_fl_v <= 1'b0;
         r_fl_pc <= '0;
         r_fl_pr <= 1'b0;
      end else begin
         r_fl_v <= fire;
         r_fpc <= w_redirect ? w_redirect_pc : fire ? (taken ? w_pdst : r_fpc + AW'(1)) : r_fpc;
         if (fire) begin
            r_fl_pc <= r_fpc;
            r_fl_pr <= taken;
         end
      end
   // queue pointers and occupancy; redirect flushes everything
   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_count <= '0;
      end else if (w_redirect) begin
         r_head <= '0;
         r_tail <= '0;
         r_count <= '0;
      end else begin
         if (push) r_tail <= r_tail + PW'(1);
         if (pop) r_head <= r_head + PW'(1);
         r_count <= r_count + CW'(push) - CW'(pop);
      end
   // queue storage, qualified by occupancy so it needs no reset
   always_ff @(posedge w_clk)
      if (push) begin
         q_ir[r_tail] <= w_imem_data;
         q_pc[r_tail] <= r_fl_pc;
         q_pr[r_tail] <= r_fl_pr;
      end
endmodule

// File: tb/tb_m_fetch_queue.sv
// tb_m_fetch_queue: directed checks of the prefetch queue against hand-derived expectations
module tb_m_fetch_queue;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [10:0] imem_addr, pdst, redirect_pc = '0, ir_pc, ir_pc4;
   logic [31:0] imem_data, ir;
   logic        pre, pr, redirect = 1'b0, halt = 1'b0, id_ready = 1'b1, ir_valid, ir_pr;
   logic        pred_en = 1'b0;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [10:0] a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // synchronous imem: data valid one cycle after address sampled
   always @(posedge clk) imem_data <= word(imem_addr);
   // predictor hit only at pc 3 when enabled
   assign pre = pred_en && imem_addr == 11'd3;
   assign pr = 1'b1;
   assign pdst = 11'h40;

   m_fetch_queue #(.DEPTH(4), .AW(11), .DW(32)) dut (
      .w_clk(clk), .w_rst_n(rst_n), .w_imem_addr(imem_addr), .w_imem_data(imem_data),
      .w_pre(pre), .w_pr(pr), .w_pdst(pdst), .w_redirect(redirect), .w_redirect_pc(redirect_pc),
      .w_halt(halt), .w_id_ready(id_ready), .w_ir_valid(ir_valid), .w_ir(ir),
      .w_ir_pc(ir_pc), .w_ir_pc4(ir_pc4), .w_ir_pr(ir_pr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   task automatic head(input string tag, input logic [10:0] pc, input logic pr_exp);
      logic [10:0] p4;
      p4 = pc + 11'd1;
      check({tag, ".valid"}, 32'(ir_valid), 32'd1);
      check({tag, ".ir"}, ir, word(pc));
      check({tag, ".pc"}, 32'(ir_pc), 32'(pc));
      check({tag, ".pc4"}, 32'(ir_pc4), 32'(p4));
      check({tag, ".pr"}, 32'(ir_pr), 32'(pr_exp));
   endtask

   task automatic empty(input string tag);
      check({tag, ".valid"}, 32'(ir_valid), 32'd0);
      check({tag, ".ir"}, ir, 32'h20);
      check({tag, ".pr"}, 32'(ir_pr), 32'd0);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      redirect = 1'b0;
      halt = 1'b0;
      cyc;
      cyc;
      rst_n = 1'b1;
   endtask

   initial begin
      // reset values and first delivery two cycles after release
      cyc;
      empty("rst");
      check("rst.pc", 32'(ir_pc), 32'd0);
      check("rst.pc4", 32'(ir_pc4), 32'd0);
      check("rst.addr", 32'(imem_addr), 32'd0);
      rst_n = 1'b1;
      cyc;
      empty("t1.c1");
      check("t1.addr", 32'(imem_addr), 32'd1);
      cyc;
      head("t1.h0", 11'd0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         cyc;
         head("t1.stream", 11'(i), 1'b0);
      end
      // ID stalled: queue fills to DEPTH and holds, then drains in order
      id_ready = 1'b0;
      do_reset;
      for (int i = 1; i <= 10; i++) begin
         cyc;
         if (i >= 6) begin
            head("t2.hold", 11'd0, 1'b0);
            check("t2.addr", 32'(imem_addr), 32'd4);
         end
      end
      id_ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         cyc;
         head("t2.drain", 11'(k), 1'b0);
      end
      // predicted-taken branch at pc 3 to 0x40
      pred_en = 1'b1;
      do_reset;
      cyc;
      for (int k = 0; k <= 2; k++) begin
         cyc;
         head("t3.seq", 11'(k), 1'b0);
      end
      cyc;
      head("t3.br", 11'd3, 1'b1);
      cyc;
      head("t3.tgt", 11'h40, 1'b0);
      cyc;
      head("t3.tgt1", 11'h41, 1'b0);
      pred_en = 1'b0;
      // redirect with three entries queued and one in flight
      id_ready = 1'b0;
      do_reset;
      for (int i = 0; i < 4; i++) cyc;
      head("t4.pre", 11'd0, 1'b0);
      redirect = 1'b1;
      redirect_pc = 11'h10;
      cyc;
      empty("t4.flush");
      check("t4.addr", 32'(imem_addr), 32'h10);
      redirect = 1'b0;
      id_ready = 1'b1;
      cyc;
      empty("t4.gap");
      check("t4.addr1", 32'(imem_addr), 32'h11);
      for (int k = 0; k < 3; k++) begin
         cyc;
         head("t4.new", 11'(11'h10 + k), 1'b0);
      end
      // redirect together with a pop, under halt
      redirect = 1'b1;
      redirect_pc = 11'h20;
      halt = 1'b1;
      cyc;
      empty("t5.flush");
      check("t5.addr", 32'(imem_addr), 32'h20);
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc;
         empty("t5.halted");
         check("t5.haddr", 32'(imem_addr), 32'h20);
      end
      halt = 1'b0;
      cyc;
      empty("t5.issue");
      check("t5.addr1", 32'(imem_addr), 32'h21);
      cyc;
      head("t5.h20", 11'h20, 1'b0);
      cyc;
      head("t5.h21", 11'h21, 1'b0);
      // halt: the in-flight fetch still lands, then the queue drains
      halt = 1'b1;
      cyc;
      head("t5.inflight", 11'h22, 1'b0);
      cyc;
      empty("t5.drained");
      check("t5.addr2", 32'(imem_addr), 32'h23);
      // address wrap at 2047 and asynchronous reset mid-stream
      halt = 1'b0;
      redirect = 1'b1;
      redirect_pc = 11'h7FE;
      cyc;
      redirect = 1'b0;
      cyc;
      cyc;
      head("t6.7fe", 11'h7FE, 1'b0);
      cyc;
      head("t6.7ff", 11'h7FF, 1'b0);
      cyc;
      head("t6.wrap", 11'h000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("t6.arst.valid", 32'(ir_valid), 32'd0);
      check("t6.arst.addr", 32'(imem_addr), 32'd0);
      check("t6.arst.pc", 32'(ir_pc), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
